// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-port memory between the fetch stage and the memory stage.
// Latency : grant in IDLE, Rdy pulse MEM_LATENCY+1 cycles after the grant; request-to-request period MEM_LATENCY+2.
// Backpr. : requests are held levels; a requester sees its Stall*_mem high until its one-cycle Rdy pulse.
//
// Ports
//   CLK, RST          clock (rising edge) and asynchronous active-low reset
//   InstrReqF, PCF    fetch read request (level) and fetch address
//   DataReqM, MemWriteM, ALUOutM, WriteDataM
//                     memory-stage access request (level), write flag, address, store data
//   MemReq, MemWe, MemAddr, MemWData, MemRData
//                     shared memory port: one-cycle strobe on grant, read data valid
//                     MEM_LATENCY cycles after the strobe cycle
//   InstrRdyF/InstrF, DataRdyM/ReadDataM
//                     one-cycle completion pulses with registered response data
//   StallF_mem, StallM_mem
//                     per-stage stall requests (request pending and not completing)
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  InstrReqF,
    input  logic [ADDR_WIDTH-1:0] PCF,
    input  logic                  DataReqM,
    input  logic                  MemWriteM,
    input  logic [ADDR_WIDTH-1:0] ALUOutM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [DATA_WIDTH-1:0] MemRData,
    output logic                  MemReq,
    output logic                  MemWe,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0] MemWData,
    output logic                  InstrRdyF,
    output logic                  DataRdyM,
    output logic [DATA_WIDTH-1:0] InstrF,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallF_mem,
    output logic                  StallM_mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // One spare bit so the counter can step past the largest legal latency (7)
    // on the capture cycle without wrapping.
    localparam int                CNT_W   = 4;
    localparam logic [CNT_W-1:0]  LAT_CNT = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   lat_cnt;
    logic [CNT_W-1:0]   lat_cnt_nxt;
    logic               owner_data;      // 1: memory stage owns the transaction, 0: fetch
    logic               owner_data_nxt;
    logic               owner_we;        // owned transaction is a store
    logic               owner_we_nxt;
    logic               last_data;       // 1: last grant went to the memory stage
    logic               last_data_nxt;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic               any_req;
    logic               grant_data;
    logic               grant_vld;
    logic               capture;

    // Round robin between two requesters: the memory stage wins alone, or on a
    // tie when the previous grant went to fetch.
    assign any_req    = InstrReqF | DataReqM;
    assign grant_data = DataReqM & (~InstrReqF | ~last_data);

    // RST is folded in so no strobe escapes while reset is held with a
    // request pending (state already sits in IDLE then).
    assign grant_vld  = (state == IDLE) & any_req & RST;

    // Read data is sampled in the BUSY cycle where the counter reaches the
    // memory latency; counting starts at 1 on the cycle after the strobe.
    assign capture    = (state == BUSY) && (lat_cnt == LAT_CNT);

    // ------------------------------------------------------------------
    // State register and transaction bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            owner_data <= 1'b0;
            owner_we   <= 1'b0;
            last_data  <= 1'b0;
        end else begin
            state      <= state_nxt;
            lat_cnt    <= lat_cnt_nxt;
            owner_data <= owner_data_nxt;
            owner_we   <= owner_we_nxt;
            last_data  <= last_data_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Response data registers: each holds until the next read for its owner.
    // Stores never touch ReadDataM.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            instr_q <= '0;
            rdata_q <= '0;
        end else if (capture) begin
            if (!owner_data) begin
                instr_q <= MemRData;
            end else if (!owner_we) begin
                rdata_q <= MemRData;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and memory-port / completion outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        lat_cnt_nxt    = lat_cnt;
        owner_data_nxt = owner_data;
        owner_we_nxt   = owner_we;
        last_data_nxt  = last_data;
        MemReq         = 1'b0;
        MemWe          = 1'b0;
        // Address and write data follow the arbitration winner at all times;
        // they only matter while MemReq is high.
        MemAddr        = grant_data ? ALUOutM : PCF;
        MemWData       = WriteDataM;
        InstrRdyF      = 1'b0;
        DataRdyM       = 1'b0;

        case (state)
            IDLE: begin
                if (grant_vld) begin
                    MemReq         = 1'b1;
                    MemWe          = grant_data & MemWriteM;
                    owner_data_nxt = grant_data;
                    owner_we_nxt   = grant_data & MemWriteM;
                    last_data_nxt  = grant_data;
                    lat_cnt_nxt    = CNT_ONE;
                    state_nxt      = BUSY;
                end
            end

            BUSY: begin
                lat_cnt_nxt = lat_cnt + CNT_ONE;
                if (capture) begin
                    state_nxt = RESP;
                end
            end

            RESP: begin
                // The pulse goes out even if the requester has since dropped
                // its request; the pipeline simply ignores it.
                InstrRdyF   = ~owner_data;
                DataRdyM    = owner_data;
                lat_cnt_nxt = '0;
                state_nxt   = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign InstrF     = instr_q;
    assign ReadDataM  = rdata_q;

    assign StallF_mem = InstrReqF & ~InstrRdyF;
    assign StallM_mem = DataReqM & ~DataRdyM;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : scoreboard bench for mem_port_arbiter; instance 0 (latency 2) carries the
//           directed scenarios, instances 1 and 2 (latency 1 and 7) the back-to-back spacing.
// Timing  : inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NI = 3;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    logic          instr_req [NI];
    logic [AW-1:0] pcf       [NI];
    logic          data_req  [NI];
    logic          mem_write [NI];
    logic [AW-1:0] alu_out   [NI];
    logic [DW-1:0] wdata     [NI];
    logic [DW-1:0] mem_rdata [NI];
    logic          mem_req   [NI];
    logic          mem_we    [NI];
    logic [AW-1:0] mem_addr  [NI];
    logic [DW-1:0] mem_wdata [NI];
    logic          instr_rdy [NI];
    logic          data_rdy  [NI];
    logic [DW-1:0] instr_f   [NI];
    logic [DW-1:0] read_data [NI];
    logic          stall_f   [NI];
    logic          stall_m   [NI];

    // Memory contents as seen by reads: tag in the upper half, low address bits below.
    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return {16'hA5A5, a[15:0]};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 7);

        int            age = 0;
        logic [AW-1:0] pend_addr = '0;

        mem_port_arbiter #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .MEM_LATENCY(L)
        ) u_dut (
            .CLK       (CLK),
            .RST       (RST),
            .InstrReqF (instr_req[g]),
            .PCF       (pcf[g]),
            .DataReqM  (data_req[g]),
            .MemWriteM (mem_write[g]),
            .ALUOutM   (alu_out[g]),
            .WriteDataM(wdata[g]),
            .MemRData  (mem_rdata[g]),
            .MemReq    (mem_req[g]),
            .MemWe     (mem_we[g]),
            .MemAddr   (mem_addr[g]),
            .MemWData  (mem_wdata[g]),
            .InstrRdyF (instr_rdy[g]),
            .DataRdyM  (data_rdy[g]),
            .InstrF    (instr_f[g]),
            .ReadDataM (read_data[g]),
            .StallF_mem(stall_f[g]),
            .StallM_mem(stall_m[g])
        );

        // Read data is valid only in the cycle exactly L cycles after the strobe;
        // any other cycle shows a changing junk pattern.
        always @(posedge CLK) begin
            if (mem_req[g] && !mem_we[g]) begin
                pend_addr <= mem_addr[g];
                age       <= 1;
            end else if (age != 0 && age < 100) begin
                age <= age + 1;
            end
        end
        assign mem_rdata[g] = (age == L) ? mem_val(pend_addr) : (32'hBAD0_0000 | cyc[15:0]);
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic          is_data;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } grant_t;

    typedef struct {
        logic          is_data;
        logic [DW-1:0] data;
    } resp_t;

    grant_t exp_grant_q[$];
    resp_t  exp_resp_q[$];
    int     grant_cyc_q[$];
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic push_grant(input logic d, input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
        grant_t ge;
        ge.is_data = d;
        ge.addr    = a;
        ge.we      = we;
        ge.wdata   = wd;
        exp_grant_q.push_back(ge);
    endtask

    task automatic push_resp(input logic d, input logic [DW-1:0] v);
        resp_t re;
        re.is_data = d;
        re.data    = v;
        exp_resp_q.push_back(re);
    endtask

    // Monitor for instance 0 (latency 2): grant-to-Rdy is 3 cycles.
    always @(negedge CLK) begin
        grant_t ge;
        resp_t  re;
        if (!RST) begin
            grant_cyc_q.delete();
        end else begin
            if (mem_req[0]) begin
                if (exp_grant_q.size() == 0) begin
                    fail_now("unexpected_grant");
                end else begin
                    ge = exp_grant_q.pop_front();
                    check("grant_addr", mem_addr[0], ge.addr);
                    check("grant_we", mem_we[0], ge.we);
                    if (ge.we) check("grant_wdata", mem_wdata[0], ge.wdata);
                    check("grant_stall", ge.is_data ? stall_m[0] : stall_f[0], 1);
                    grant_cyc_q.push_back(cyc);
                end
            end
            if (instr_rdy[0] || data_rdy[0]) begin
                if (exp_resp_q.size() == 0) begin
                    fail_now("unexpected_rdy");
                end else begin
                    re = exp_resp_q.pop_front();
                    check("rdy_owner_data", data_rdy[0], re.is_data);
                    check("rdy_owner_instr", instr_rdy[0], !re.is_data);
                    check("rdy_value", re.is_data ? read_data[0] : instr_f[0], re.data);
                    check("rdy_stall", re.is_data ? stall_m[0] : stall_f[0], 0);
                end
                if (grant_cyc_q.size() == 0) fail_now("rdy_without_grant");
                else check("rdy_latency", cyc - grant_cyc_q.pop_front(), 3);
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_rdy(input bit is_data, input bit chk_stall);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (is_data ? data_rdy[0] : instr_rdy[0]) seen = 1;
            else if (chk_stall) check(is_data ? "stall_m_hold" : "stall_f_hold",
                                      is_data ? stall_m[0] : stall_f[0], 1);
        end
        if (!seen) fail_now(is_data ? "data_rdy_timeout" : "instr_rdy_timeout");
    endtask

    // Raise now, hold until Rdy, drop just after the edge that ends the pulse.
    task automatic fetch(input logic [AW-1:0] a);
        instr_req[0] = 1'b1;
        pcf[0]       = a;
        wait_rdy(1'b0, 1'b1);
        tick();
        instr_req[0] = 1'b0;
    endtask

    task automatic data_acc(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
        data_req[0]  = 1'b1;
        mem_write[0] = we;
        alu_out[0]   = a;
        wdata[0]     = wd;
        wait_rdy(1'b1, 1'b1);
        tick();
        data_req[0]  = 1'b0;
        mem_write[0] = 1'b0;
    endtask

    // Fetch held high on instance k; three Rdy pulses expected.
    task automatic back_to_back(input int k, input int first_lat, input int period);
        int rdy_cyc[$];
        int start;
        instr_req[k] = 1'b1;
        pcf[k]       = 32'h300;
        start        = cyc;
        for (int i = 0; i < 80 && rdy_cyc.size() < 3; i++) begin
            @(negedge CLK);
            if (instr_rdy[k]) begin
                rdy_cyc.push_back(cyc);
                check("bb_instr", instr_f[k], 32'hA5A5_0300);
            end
        end
        tick();
        instr_req[k] = 1'b0;
        if (rdy_cyc.size() < 3) begin
            fail_now("bb_rdy_timeout");
        end else begin
            check("bb_first_latency", rdy_cyc[0] - start, first_lat);
            check("bb_period_1", rdy_cyc[1] - rdy_cyc[0], period);
            check("bb_period_2", rdy_cyc[2] - rdy_cyc[1], period);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        for (int i = 0; i < NI; i++) begin
            instr_req[i] = 1'b0;
            pcf[i]       = '0;
            data_req[i]  = 1'b0;
            mem_write[i] = 1'b0;
            alu_out[i]   = '0;
            wdata[i]     = '0;
        end

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_memreq", mem_req[0], 0);
        check("rst_memwe", mem_we[0], 0);
        check("rst_instr_rdy", instr_rdy[0], 0);
        check("rst_data_rdy", data_rdy[0], 0);
        check("rst_instr_f", instr_f[0], 0);
        check("rst_read_data", read_data[0], 0);
        tick();
        RST = 1'b1;
        @(negedge CLK);
        check("idle_memreq", mem_req[0], 0);
        check("idle_stall_f", stall_f[0], 0);

        // Single fetch at 0x40
        push_grant(1'b0, 32'h40, 1'b0, '0);
        push_resp(1'b0, 32'hA5A5_0040);
        tick();
        fetch(32'h40);

        // Reset again so the next tie is the first since reset; InstrF clears
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("rst2_instr_f", instr_f[0], 0);
        tick();
        RST = 1'b1;

        // Tie: data first, then fetch wins the tie against the data stage's next access
        push_grant(1'b1, 32'h200, 1'b0, '0);
        push_grant(1'b0, 32'h44, 1'b0, '0);
        push_grant(1'b1, 32'h204, 1'b0, '0);
        push_resp(1'b1, 32'hA5A5_0200);
        push_resp(1'b0, 32'hA5A5_0044);
        push_resp(1'b1, 32'hA5A5_0204);
        tick();
        fork
            fetch(32'h44);
            begin
                data_acc(32'h200, 1'b0, '0);
                data_acc(32'h204, 1'b0, '0);
            end
        join

        // Store: strobe carries address/data, ReadDataM keeps the last read
        push_grant(1'b1, 32'h100, 1'b1, 32'hDEAD_BEEF);
        push_resp(1'b1, 32'hA5A5_0204);
        tick();
        data_acc(32'h100, 1'b1, 32'hDEAD_BEEF);
        check("store_keeps_instr", instr_f[0], 32'hA5A5_0044);

        // Request dropped right after its grant still completes
        push_grant(1'b0, 32'hC0, 1'b0, '0);
        push_resp(1'b0, 32'hA5A5_00C0);
        tick();
        instr_req[0] = 1'b1;
        pcf[0]       = 32'hC0;
        tick();
        instr_req[0] = 1'b0;
        wait_rdy(1'b0, 1'b0);

        // Reset one cycle into a fetch aborts it; held request is re-granted on release
        push_grant(1'b0, 32'h80, 1'b0, '0);
        tick();
        instr_req[0] = 1'b1;
        pcf[0]       = 32'h80;
        @(negedge CLK);
        check("abort_grant", mem_req[0], 1);
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("abort_memreq", mem_req[0], 0);
        check("abort_instr_rdy", instr_rdy[0], 0);
        check("abort_instr_f", instr_f[0], 0);
        tick();
        tick();
        push_grant(1'b0, 32'h80, 1'b0, '0);
        push_resp(1'b0, 32'hA5A5_0080);
        RST = 1'b1;
        @(negedge CLK);
        check("regrant_memreq", mem_req[0], 1);
        wait_rdy(1'b0, 1'b0);
        tick();
        instr_req[0] = 1'b0;

        // Back-to-back fetches at latency 1 and 7
        tick();
        fork
            back_to_back(1, 2, 3);
            back_to_back(2, 8, 9);
        join

        repeat (5) tick();
        check("grant_q_drained", exp_grant_q.size(), 0);
        check("resp_q_drained", exp_resp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, memory data width.
REQ-003 SHALL have parameter MEM_LATENCY, default 2, cycles from the memory-request cycle to valid MemRData; legal range 1..7.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port InstrReqF  input  1  fetch-stage read request, level, held until InstrRdyF.
REQ-007 SHALL have port PCF  input  ADDR_WIDTH  fetch address.
REQ-008 SHALL have port DataReqM  input  1  memory-stage access request, level, held until DataRdyM.
REQ-009 SHALL have port MemWriteM  input  1  memory-stage access is a write when 1.
REQ-010 SHALL have port ALUOutM  input  ADDR_WIDTH  data address.
REQ-011 SHALL have port WriteDataM  input  DATA_WIDTH  store data.
REQ-012 SHALL have port MemRData  input  DATA_WIDTH  read data from the shared single-port memory.
REQ-013 SHALL have port MemReq, MemWe  output  1 each  one-cycle memory strobe and write enable.
REQ-014 SHALL have port MemAddr, MemWData  output  ADDR_WIDTH / DATA_WIDTH  memory address and write data.
REQ-015 SHALL have port InstrRdyF, DataRdyM  output  1 each  one-cycle completion pulses.
REQ-016 SHALL have port InstrF, ReadDataM  output  DATA_WIDTH  registered response data.
REQ-017 SHALL have port StallF_mem, StallM_mem  output  1 each  stall requests ORed into the hazard-unit stall.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY, RESP; grants occur only in IDLE.
REQ-019 In IDLE with any request pending, SHALL grant in that cycle: MemReq=1, MemAddr and MemWe/MemWData driven from the winner (MemWe=MemWriteM, data owner only), owner latched, latency counter loaded with 1, next state BUSY.
REQ-020 Arbitration SHALL be: a single requester wins; when both request, the requester not granted last wins (round-robin); the last-grant flag resets to "instr", so the first tie goes to data.
REQ-021 MemReq, MemWe SHALL be 0 in every non-grant cycle; MemAddr/MemWData are don't-care then.
REQ-022 In BUSY, the counter SHALL increment each cycle; in the cycle counter==MEM_LATENCY, the owner's data register SHALL capture MemRData (reads only) and next state SHALL be RESP.
REQ-023 With MEM_LATENCY=1, BUSY SHALL last exactly one cycle.
REQ-024 In RESP, SHALL assert the owner's Rdy for exactly one cycle, with InstrF or ReadDataM valid, then go to IDLE unconditionally.
REQ-025 Grant-to-Rdy latency SHALL be MEM_LATENCY+1 cycles; the minimum request-to-request period SHALL be MEM_LATENCY+2 cycles.
REQ-026 For writes, DataRdyM SHALL pulse on the same schedule, and ReadDataM SHALL hold its previous value.
REQ-027 InstrF and ReadDataM SHALL hold their value until the next capture for the same owner.
REQ-028 StallF_mem SHALL equal InstrReqF & ~InstrRdyF; StallM_mem SHALL equal DataReqM & ~DataRdyM (combinational).
REQ-029 A request deasserted mid-transaction SHALL NOT abort it; the Rdy pulse still occurs and is ignored.
REQ-030 A request asserted while BUSY or RESP SHALL wait and is arbitrated in the next IDLE cycle.

Reset
REQ-031 While RST=0, SHALL force state IDLE, counter 0, last-grant flag "instr", MemReq/MemWe/InstrRdyF/DataRdyM 0, InstrF/ReadDataM 0.
REQ-032 Reset asserted mid-transaction SHALL abort it immediately; no Rdy pulse SHALL follow reset release.

Verification
REQ-033 With MEM_LATENCY=2, InstrReqF=1, PCF=0x40 -> MemReq=1, MemAddr=0x40 at cycle T; InstrRdyF=1 at T+3 with InstrF=MemRData sampled at T+2; StallF_mem=1 from T to T+2.
REQ-034 InstrReqF and DataReqM rise together after reset -> data is granted first; fetch is granted in the IDLE cycle after DataRdyM; next tie -> instr.
REQ-035 DataReqM=1, MemWriteM=1, ALUOutM=0x100, WriteDataM=0xDEADBEEF -> MemWe=1 for one cycle with that address/data; DataRdyM at T+3; ReadDataM unchanged.
REQ-036 RST pulled low at T+1 of a fetch -> MemReq=0, state IDLE, no InstrRdyF after release; a request held high is re-granted in the first cycle after release.
REQ-037 MEM_LATENCY=1 and MEM_LATENCY=7 back-to-back fetches -> Rdy pulses spaced exactly 3 and 9 cycles apart respectively.
